mac_bank_scheduler: RTL and testbench
=====================================

// Module: mac_bank_scheduler
// PURPOSE
//   Time-shares one weight-RAM read port and its multiplier bank among LAYERS neuron layers.
//   Arbitrates requests round-robin and streams batch addresses (base + batch index) to the RAM.
//   Issues per-batch step strobes to the owning layer, aligned with RAM data.
//   Signals per-layer completion. Sits between the layer instances and the shared RAM/MAC resources.
// PARAMETERS
//   LAYERS      2  number of requesting layers (>=1)
//   RAM_ADDR_W  8  weight RAM address width
//   BATCH_CNT_W 8  width of per-layer batch count
//   RAM_LATENCY 1  cycles from ram_rd to valid ram_values (>=1)
// PORTS
//   clk          in   1                       clock
//   nreset       in   1                       async reset, active low
//   req          in   LAYERS                  per-layer request; hold until done
//   base_addr    in   LAYERS*RAM_ADDR_W       per-layer first weight address; layer k at [k*RAM_ADDR_W +: RAM_ADDR_W]
//   batches      in   LAYERS*BATCH_CNT_W      per-layer batch count; layer k at [k*BATCH_CNT_W +: BATCH_CNT_W]
//   grant        out  LAYERS                  one-hot owner of the RAM/MAC bank
//   ram_addr     out  RAM_ADDR_W              weight RAM address
//   ram_rd       out  1                       RAM read strobe
//   layer_enable out  LAYERS                  step strobe; ram_values valid for owner this cycle
//   done         out  LAYERS                  1-cycle completion pulse
//   busy         out  1                       grant != 0
//   pause        in   1                       only with SCHED_PAUSE_EN
// BEHAVIOUR
//   - Reset (async, nreset=0): grant=0, ram_addr=0, ram_rd=0, layer_enable=0, done=0, busy=0.
//     Also state=IDLE, batch counter=0, delay line cleared, RR pointer=0 (layer 0 highest priority).
//   - FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE. All outputs registered.
//   - IDLE: if any req, pick first requester at or after RR pointer (wrapping).
//     Next cycle: grant set, cnt=0; latch base_addr and batches of winner.
//     If latched batches=0, go straight to DONE; otherwise go to ISSUE.
//   - ISSUE: each cycle ram_rd=1, ram_addr=base+cnt (mod 2^RAM_ADDR_W), cnt++.
//     After the read with cnt=batches-1, go to DRAIN. First ram_rd is in the same cycle as the grant.
//   - layer_enable[g] = ram_rd delayed RAM_LATENCY cycles (shift register), gated by grant.
//     Exactly `batches` pulses per job.
//   - DRAIN: wait until the delay line is empty, then go to DONE.
//   - DONE: done[g]=1 for one cycle, grant=0, RR pointer=g+1 mod LAYERS, return to IDLE.
//     done is asserted the cycle after the last layer_enable.
//     Earliest next grant: 2 cycles after the done cycle (IDLE decides, registered grant follows).
//   - Inputs base_addr and batches are sampled only at grant; later changes are ignored.
//   - Abort: req[g] low while granted in ISSUE -> stop ram_rd next cycle and enter DRAIN.
//     Pending layer_enable pulses still emitted; DONE cycle omits the done pulse. RR pointer still advances.
//   - req of non-owners is ignored while busy. No preemption.
//   - Reset mid-job: all outputs drop asynchronously, job is lost, no done pulse.
// CONFIGURATION
//   SCHED_PAUSE_EN defined: port `pause` exists.
//     pause=1 in ISSUE -> ram_rd=0 and cnt/ram_addr held; resumes on the next cycle with pause=0.
//     Delay line keeps shifting, so stalls appear as gaps in layer_enable. Ignored in other states.
//   SCHED_PAUSE_EN undefined: no pause port; ISSUE never stalls.
// TESTING (LAYERS=2, RAM_ADDR_W=8, RAM_LATENCY=1 unless noted)
//   1. req[0], base0=0x10, batches0=3 -> ram_addr 0x10,0x11,0x12 on 3 consecutive ram_rd cycles.
//      layer_enable[0] on the 3 following cycles, then done[0] 1 cycle, grant->0.
//   2. req=2'b11 right after reset, batches=2 each -> layer 0 served first, then layer 1.
//      Repeat with req=2'b11 held -> order alternates 0,1,0,1.
//   3. batches0=0 -> grant[0] 1 cycle, no ram_rd, no layer_enable, done[0] pulses.
//   4. base0=0xFE, batches0=4 -> addresses 0xFE,0xFF,0x00,0x01.
//      RAM_LATENCY=3: layer_enable 3 cycles after each ram_rd.
//   5. batches0=8; drop req[0] after 3rd ram_rd -> exactly 3 layer_enable, no done.
//      nreset low during ISSUE -> all outputs 0 immediately.
//   6. SCHED_PAUSE_EN, batches0=4, pause high for 2 cycles after 1st read.
//      -> addresses 0x10,(stall x2),0x11,0x12,0x13; still 4 layer_enable pulses.

Source files
------------

// File: rtl/mac_bank_scheduler_if.sv
// Request/grant and weight-RAM bundle between the layer instances and mac_bank_scheduler.
// The pause signal exists only when SCHED_PAUSE_EN is defined.
interface mac_bank_scheduler_if #(
  parameter int unsigned LAYERS      = 2,
  parameter int unsigned RAM_ADDR_W  = 8,
  parameter int unsigned BATCH_CNT_W = 8
);
  logic [LAYERS-1:0]             req;
  logic [LAYERS*RAM_ADDR_W-1:0]  base_addr;
  logic [LAYERS*BATCH_CNT_W-1:0] batches;
  logic [LAYERS-1:0]             grant;
  logic [RAM_ADDR_W-1:0]         ram_addr;
  logic                          ram_rd;
  logic [LAYERS-1:0]             layer_enable;
  logic [LAYERS-1:0]             done;
  logic                          busy;
`ifdef SCHED_PAUSE_EN
  logic                          pause;

  modport master (
    output req, base_addr, batches, pause,
    input  grant, ram_addr, ram_rd, layer_enable, done, busy
  );
  modport slave (
    input  req, base_addr, batches, pause,
    output grant, ram_addr, ram_rd, layer_enable, done, busy
  );
`else
  modport master (
    output req, base_addr, batches,
    input  grant, ram_addr, ram_rd, layer_enable, done, busy
  );
  modport slave (
    input  req, base_addr, batches,
    output grant, ram_addr, ram_rd, layer_enable, done, busy
  );
`endif
endinterface

// File: rtl/mac_bank_scheduler.sv
// Round-robin time-sharing of one weight-RAM read port / MAC bank among LAYERS layers.
// Define SCHED_PAUSE_EN to add the ISSUE-stalling pause input.
module mac_bank_scheduler #(
  parameter int unsigned LAYERS      = 2,
  parameter int unsigned RAM_ADDR_W  = 8,
  parameter int unsigned BATCH_CNT_W = 8,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 nreset,
  mac_bank_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [LAYERS-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [RAM_ADDR_W-1:0]   base_q, base_d;
  logic [RAM_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [BATCH_CNT_W-1:0]  batches_q, batches_d;
  logic [BATCH_CNT_W-1:0]  cnt_q, cnt_d;
  logic                    ram_rd_q, ram_rd_d;
  logic [RAM_LATENCY-1:0]  pipe_q, pipe_d;
  logic [LAYERS-1:0]       layer_enable_q, layer_enable_d;
  logic [LAYERS-1:0]       done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    aborted_q, aborted_d;

  logic                    pause_w;
  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [RAM_ADDR_W-1:0]   win_base;
  logic [BATCH_CNT_W-1:0]  win_batches;
  logic                    last_read;

`ifdef SCHED_PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin : arb
    int unsigned k;
    k         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      k = (32'(rr_q) + i) % LAYERS;
      if (!win_found && bus.req[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end

  assign win_base    = bus.base_addr[win_idx*RAM_ADDR_W +: RAM_ADDR_W];
  assign win_batches = bus.batches[win_idx*BATCH_CNT_W +: BATCH_CNT_W];
  assign last_read   = ram_rd_q && (cnt_q == batches_q - BATCH_CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    base_d     = base_q;
    batches_d  = batches_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
    done_d     = '0;
    aborted_d  = aborted_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          base_d           = win_base;
          batches_d        = win_batches;
          cnt_d            = '0;
          aborted_d        = 1'b0;
          if (win_batches == '0) begin
            // Empty job: the grant cycle is itself the DONE cycle.
            state_d         = S_DONE;
            done_d[win_idx] = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            ram_rd_d   = 1'b1;
            ram_addr_d = win_base;
          end
        end
      end

      S_ISSUE: begin
        if (!bus.req[owner_q]) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (last_read) begin
          state_d = S_DRAIN;
        end else begin
          // cnt advances only past a read actually presented, so stalls hold it.
          cnt_d = ram_rd_q ? cnt_q + BATCH_CNT_W'(1) : cnt_q;
          if (!pause_w) begin
            ram_rd_d   = 1'b1;
            ram_addr_d = base_q + RAM_ADDR_W'(cnt_d);
          end
        end
      end

      S_DRAIN: begin
        if (pipe_q == '0) begin
          state_d = S_DONE;
          done_d  = aborted_q ? '0 : grant_q;
        end
      end

      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
        if (32'(owner_q) + 32'd1 == LAYERS) rr_d = '0;
        else                                rr_d = owner_q + IDX_W'(1);
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = |grant_d;
  end

  // pipe_q[i] is ram_rd delayed i cycles; the output register adds the final stage.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = ram_rd_d;
    for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    layer_enable_d = pipe_q[RAM_LATENCY-1] ? grant_q : '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      owner_q        <= '0;
      rr_q           <= '0;
      base_q         <= '0;
      batches_q      <= '0;
      cnt_q          <= '0;
      ram_addr_q     <= '0;
      ram_rd_q       <= 1'b0;
      pipe_q         <= '0;
      layer_enable_q <= '0;
      done_q         <= '0;
      busy_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      owner_q        <= owner_d;
      rr_q           <= rr_d;
      base_q         <= base_d;
      batches_q      <= batches_d;
      cnt_q          <= cnt_d;
      ram_addr_q     <= ram_addr_d;
      ram_rd_q       <= ram_rd_d;
      pipe_q         <= pipe_d;
      layer_enable_q <= layer_enable_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      aborted_q      <= aborted_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_rd       = ram_rd_q;
  assign bus.layer_enable = layer_enable_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mac_bank_scheduler.sv
// Bench for mac_bank_scheduler: one DUT with RAM_LATENCY=1 and one with RAM_LATENCY=3, selected by sel.
// Expected cycle traces are computed per job from read/enable/done timing arithmetic.
module tb_mac_bank_scheduler;
  localparam int unsigned LAYERS = 2;
  localparam int unsigned AW     = 8;
  localparam int unsigned BW     = 8;

  logic        clk = 1'b0;
  logic        nreset;
  logic        sel;
  logic [1:0]  req_v;
  logic [15:0] base_v;
  logic [15:0] batches_v;
  logic        pause_v;

  int vectors     = 0;
  int miscompares = 0;
  int ptr[2];
  int jobn        = 0;

  always #5 clk = ~clk;

  mac_bank_scheduler_if #(.LAYERS(LAYERS), .RAM_ADDR_W(AW), .BATCH_CNT_W(BW)) if1 ();
  mac_bank_scheduler_if #(.LAYERS(LAYERS), .RAM_ADDR_W(AW), .BATCH_CNT_W(BW)) if3 ();

  mac_bank_scheduler #(.LAYERS(LAYERS), .RAM_ADDR_W(AW), .BATCH_CNT_W(BW), .RAM_LATENCY(1))
    dut1 (.clk(clk), .nreset(nreset), .bus(if1));
  mac_bank_scheduler #(.LAYERS(LAYERS), .RAM_ADDR_W(AW), .BATCH_CNT_W(BW), .RAM_LATENCY(3))
    dut3 (.clk(clk), .nreset(nreset), .bus(if3));

  assign if1.req       = sel ? 2'b00 : req_v;
  assign if3.req       = sel ? req_v : 2'b00;
  assign if1.base_addr = base_v;
  assign if3.base_addr = base_v;
  assign if1.batches   = batches_v;
  assign if3.batches   = batches_v;
`ifdef SCHED_PAUSE_EN
  assign if1.pause     = pause_v;
  assign if3.pause     = pause_v;
`endif

  // Packed view {grant, busy, ram_rd, ram_addr, layer_enable, done}.
  logic [15:0] raw1, raw3, obs;
  assign raw1 = {if1.grant, if1.busy, if1.ram_rd, if1.ram_addr, if1.layer_enable, if1.done};
  assign raw3 = {if3.grant, if3.busy, if3.ram_rd, if3.ram_addr, if3.layer_enable, if3.done};
  assign obs  = sel ? {raw3[15:12], raw3[12] ? raw3[11:4] : 8'h00, raw3[3:0]}
                    : {raw1[15:12], raw1[12] ? raw1[11:4] : 8'h00, raw1[3:0]};

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold: 0 drop owner's req at done, 1 keep all, 2 drop all. abort_at>0: drop req after that many reads.
  task automatic do_job(input int hold, input int abort_at, input int pause_at, input int pause_len,
                        input bit scramble, output int won);
    int unsigned lat, b, base, nr, d, waited;
    int unsigned rc[$];
    logic [1:0]  oh, g;
    logic        e_rd, e_le;
    logic [7:0]  e_addr;
    int          w;
    lat = sel ? 3 : 1;
    w   = -1;
    for (int unsigned i = 0; i < 2; i++) begin
      int k;
      k = (ptr[sel] + int'(i)) % 2;
      if (w < 0 && req_v[k]) w = k;
    end
    if (w < 0) w = 0;
    won  = w;
    oh   = 2'b01 << w;
    b    = int'(batches_v[w*8 +: 8]);
    base = int'(base_v[w*8 +: 8]);
    nr   = (abort_at > 0) ? abort_at : b;
    for (int unsigned i = 0; i < nr; i++)
      rc.push_back(i + ((pause_at >= 0 && int'(i) > pause_at) ? pause_len : 0));
    d = (nr == 0) ? 0 : rc[nr-1] + lat + 1;

    waited = 0;
    do begin
      tick();
      waited++;
    end while (obs[15:14] == 2'b00 && waited < 8);
    chk($sformatf("job%0d grant_wait", jobn), waited, 1);

    for (int unsigned c = 0; c <= d + 1; c++) begin
      if (c > 0) tick();
      e_rd = 1'b0; e_addr = 8'h00; e_le = 1'b0;
      foreach (rc[i]) begin
        if (rc[i] == c) begin
          e_rd   = 1'b1;
          e_addr = 8'(base + i);
        end
        if (rc[i] + lat == c) e_le = 1'b1;
      end
      g = (c <= d) ? oh : 2'b00;
      chk($sformatf("job%0d lat%0d c%0d", jobn, lat, c), obs,
          {g, |g, e_rd, e_addr, e_le ? oh : 2'b00, (c == d && abort_at == 0) ? oh : 2'b00});
      if (c == 0 && scramble) begin
        base_v    = 16'($urandom);
        batches_v = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
      end
      if (pause_at >= 0 && int'(c) == pause_at) pause_v = 1'b1;
      if (pause_at >= 0 && int'(c) == pause_at + pause_len) pause_v = 1'b0;
      if (abort_at > 0 && int'(c) == abort_at - 1) req_v[w] = 1'b0;
      if (c == d && abort_at == 0) begin
        if (hold == 0) req_v[w] = 1'b0;
        if (hold == 2) req_v = 2'b00;
      end
    end
    ptr[sel] = (w + 1) % 2;
    jobn++;
  endtask

  initial begin
    int won, b, ab, pa, pl;
    nreset = 1'b0; sel = 1'b0; req_v = 2'b00; base_v = '0; batches_v = '0; pause_v = 1'b0;
    ptr[0] = 0; ptr[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lat1", raw1, 16'h0000);
    chk("reset_lat3", raw3, 16'h0000);
    nreset = 1'b1;
    tick();

    // Both layers requesting from reset: 0,1,0,1.
    base_v = 16'h4020; batches_v = 16'h0202; req_v = 2'b11;
    for (int unsigned i = 0; i < 4; i++) begin
      do_job((i == 3) ? 2 : 1, 0, -1, 0, 1'b0, won);
      chk($sformatf("rr_order%0d", i), won, i % 2);
    end

    // Three-batch job at 0x10.
    base_v = 16'h0010; batches_v = 16'h0003; req_v = 2'b01;
    do_job(0, 0, -1, 0, 1'b0, won);
    chk("job1_owner", won, 0);

    // Zero batches: grant and done only.
    batches_v = 16'h0000; req_v = 2'b01;
    do_job(0, 0, -1, 0, 1'b0, won);

    // Address wrap, both latencies; inputs scrambled after grant.
    for (int unsigned s = 0; s < 2; s++) begin
      sel = s[0]; base_v = 16'h00FE; batches_v = 16'h0004; req_v = 2'b01;
      do_job(0, 0, -1, 0, 1'b1, won);
    end
    sel = 1'b0;

    // Abort after the third read of eight.
    base_v = 16'h0010; batches_v = 16'h0008; req_v = 2'b01;
    do_job(0, 3, -1, 0, 1'b0, won);

    // Reset in the middle of ISSUE.
    base_v = 16'h0010; batches_v = 16'h0008; req_v = 2'b01;
    repeat (3) tick();
    chk("pre_reset_rd", {31'd0, if1.ram_rd}, 1);
    #2 nreset = 1'b0;
    #1;
    chk("mid_reset_out", raw1, 16'h0000);
    req_v = 2'b00;
    tick();
    nreset = 1'b1;
    ptr[0] = 0; ptr[1] = 0;
    tick();
    chk("post_reset_idle", raw1, 16'h0000);
    batches_v = 16'h0101; req_v = 2'b11;
    do_job(2, 0, -1, 0, 1'b0, won);
    chk("rr_after_reset", won, 0);

`ifdef SCHED_PAUSE_EN
    base_v = 16'h0010; batches_v = 16'h0004; req_v = 2'b01;
    do_job(0, 0, 0, 2, 1'b0, won);
`endif

    // Randomized jobs across both latencies.
    for (int unsigned n = 0; n < 40; n++) begin
      if (req_v == 2'b00) begin
        sel       = 1'($urandom);
        base_v    = 16'($urandom);
        batches_v = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
      end
      req_v = req_v | 2'($urandom_range(1, 3));
      b  = int'(batches_v[((ptr[sel] + ((req_v[ptr[sel]]) ? 0 : 1)) % 2)*8 +: 8]);
      ab = 0; pa = -1; pl = 0;
      if (b >= 2 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, b - 1);
`ifdef SCHED_PAUSE_EN
      else if (b >= 2 && $urandom_range(0, 2) == 0) begin
        pa = $urandom_range(0, b - 2);
        pl = $urandom_range(1, 3);
      end
`endif
      do_job(0, ab, pa, pl, 1'($urandom), won);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
